// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the iterative FP divider: field widths,
// special constants, FSM state encoding and operand classification.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int BIAS     = 127;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        ROUND,
        DONE
    } div_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

    // Takes the magnitude bits only; the sign never affects the class.
    // Exponent 0 counts as zero, so subnormals are flushed here.
    function automatic fp_class_t classify(input logic [FP_W-2:0] x);
        fp_class_t             c;
        logic [FP_EXP_W-1:0]   e;
        logic [FP_MAN_W-1:0]   m;
        e         = x[FP_W-2 -: FP_EXP_W];
        m         = x[FP_MAN_W-1:0];
        c.is_zero = (e == '0);
        c.is_inf  = (e == '1) && (m == '0);
        c.is_nan  = (e == '1) && (m != '0);
        c.is_snan = c.is_nan && !m[FP_MAN_W-1];
        return c;
    endfunction

    function automatic logic is_special(input logic [FP_W-2:0] x);
        logic [FP_EXP_W-1:0] e;
        e = x[FP_W-2 -: FP_EXP_W];
        return (e == '0) || (e == '1);
    endfunction

endpackage

// File: rtl/fp_mant_div_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle,
// Q = floor(ma * 2^(QBITS-1) / mb) plus the final partial remainder.
module fp_mant_div_core #(
    parameter int MAN_W = 23,
    parameter int QBITS = MAN_W + 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [MAN_W:0]   ma,
    input  logic [MAN_W:0]   mb,
    output logic [QBITS-1:0] Q,
    output logic [MAN_W+1:0] rem,
    output logic             finished
);

    localparam int CNT_W = $clog2(QBITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QBITS - 1);

    logic [MAN_W+1:0] prem;
    logic [MAN_W:0]   divisor;
    logic [QBITS-1:0] quot;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [MAN_W+2:0] diff;
    logic             qbit;

    assign diff     = {1'b0, prem} - {2'b00, divisor};
    assign qbit     = ~diff[MAN_W+2];
    assign finished = active && (cnt == LAST);
    assign Q        = quot;
    assign rem      = prem;

    // The remainder is kept pre-shifted for the next trial subtraction;
    // a shift never changes whether it is zero, which is all the rounder needs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            prem    <= '0;
            divisor <= '0;
            quot    <= '0;
            cnt     <= '0;
            active  <= 1'b0;
        end else if (start) begin
            prem    <= {1'b0, ma};
            divisor <= mb;
            quot    <= '0;
            cnt     <= '0;
            active  <= 1'b1;
        end else if (active) begin
            quot <= {quot[QBITS-2:0], qbit};
            prem <= (qbit ? diff[MAN_W+1:0] : prem) << 1;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider: FSM, special-operand bypass, exponent path,
// round-to-nearest-even and the registered result/flags.
module fp_div_iter
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int QBITS = MAN_W + 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 en,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] R,
    output logic                 io_flag,
    output logic                 dz_flag,
    output logic                 of_flag,
    output logic                 uf_flag,
    output logic                 i_flag
);

    localparam int W = EXP_W + MAN_W + 1;
    localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_BIAS = (EXP_W+2)'(BIAS);
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);

    div_state_t state, next_state;

    logic [W-1:0]     a_q, b_q;
    logic             sign_q;
    fp_class_t        ca, cb;
    logic             start, core_finished;
    logic [QBITS-1:0] q;
    logic [MAN_W+1:0] rem;
    logic [4:0]       flags_q;

    logic [W-1:0]     spec_r, rnd_r;
    logic [4:0]       spec_f, rnd_f;

    logic [MAN_W:0]          mant;
    logic [MAN_W+1:0]        mant_r;
    logic [MAN_W-1:0]        frac;
    logic                    guard, sticky, round_up;
    logic signed [EXP_W+1:0] e_pre, e_fin;

    assign sign_q = a_q[W-1] ^ b_q[W-1];
    assign ca     = classify(a_q[W-2:0]);
    assign cb     = classify(b_q[W-2:0]);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign {io_flag, dz_flag, of_flag, uf_flag, i_flag} = flags_q;

    fp_mant_div_core #(
        .MAN_W (MAN_W),
        .QBITS (QBITS)
    ) u_core (
        .clk      (clk),
        .arst     (arst),
        .start    (start),
        .ma       ({1'b1, a[MAN_W-1:0]}),
        .mb       ({1'b1, b[MAN_W-1:0]}),
        .Q        (q),
        .rem      (rem),
        .finished (core_finished)
    );

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (is_special(a[W-2:0]) || is_special(b[W-2:0])) begin
                        next_state = SPECIAL;
                    end else begin
                        next_state = DIVIDE;
                        start      = 1'b1;
                    end
                end
            end
            SPECIAL: next_state = DONE;
            DIVIDE:  if (core_finished) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NaN checks come first; inf dividends beat zero divisors so inf/0 raises no dz.
    always_comb begin
        spec_r = '0;
        spec_f = '0;
        if (ca.is_nan || cb.is_nan) begin
            spec_r    = QNAN;
            spec_f[4] = ca.is_snan | cb.is_snan;
        end else if ((ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
            spec_r    = QNAN;
            spec_f[4] = 1'b1;
        end else if (ca.is_inf) begin
            spec_r = {sign_q, POS_INF[W-2:0]};
        end else if (cb.is_inf) begin
            spec_r = {sign_q, {(W-1){1'b0}}};
        end else if (cb.is_zero) begin
            spec_r    = {sign_q, POS_INF[W-2:0]};
            spec_f[3] = 1'b1;
        end else begin
            spec_r = {sign_q, {(W-1){1'b0}}};
        end
    end

    // Quotient lies in [2^25, 2^27); when the top bit is clear the true
    // ratio was below 1, so one extra bit feeds the mantissa and e drops by one.
    always_comb begin
        e_pre = $signed({2'b00, a_q[W-2 -: EXP_W]}) - $signed({2'b00, b_q[W-2 -: EXP_W]}) + E_BIAS;
        if (q[QBITS-1]) begin
            mant   = q[QBITS-1:3];
            guard  = q[2];
            sticky = (|q[1:0]) | (|rem);
        end else begin
            mant   = q[QBITS-2:2];
            guard  = q[1];
            sticky = q[0] | (|rem);
            e_pre  = e_pre - E_ONE;
        end
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
        if (mant_r[MAN_W+1]) begin
            frac  = mant_r[MAN_W:1];
            e_fin = e_pre + E_ONE;
        end else begin
            frac  = mant_r[MAN_W-1:0];
            e_fin = e_pre;
        end

        rnd_r = '0;
        rnd_f = '0;
        if (e_fin >= E_MAX) begin
            rnd_r = {sign_q, POS_INF[W-2:0]};
            rnd_f = 5'b00101;
        end else if (e_fin <= '0) begin
            rnd_r = {sign_q, {(W-1){1'b0}}};
            rnd_f = 5'b00011;
        end else begin
            rnd_r    = {sign_q, e_fin[EXP_W-1:0], frac};
            rnd_f[0] = guard | sticky;
        end
    end

    // Operands are latched on the accepting edge; results only move on DONE entry.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            a_q     <= '0;
            b_q     <= '0;
            R       <= '0;
            flags_q <= '0;
        end else begin
            if (state == IDLE && en) begin
                a_q <= a;
                b_q <= b;
            end
            if (state == SPECIAL) begin
                R       <= spec_r;
                flags_q <= spec_f;
            end else if (state == ROUND) begin
                R       <= rnd_r;
                flags_q <= rnd_f;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed vector bench for fp_div_iter: table of hand-computed results,
// plus sequences for ignored starts and asynchronous abort.
module tb_fp_div_iter;

    logic        clk  = 1'b0;
    logic        arst = 1'b0;
    logic        en   = 1'b0;
    logic [31:0] a    = '0;
    logic [31:0] b    = '0;
    logic        busy, done;
    logic [31:0] R;
    logic        io_flag, dz_flag, of_flag, uf_flag, i_flag;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;

    // flag order {io, dz, of, uf, i}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    assign flags = {io_flag, dz_flag, of_flag, uf_flag, i_flag};

    always #5 clk = ~clk;

    fp_div_iter dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .R       (R),
        .io_flag (io_flag),
        .dz_flag (dz_flag),
        .of_flag (of_flag),
        .uf_flag (uf_flag),
        .i_flag  (i_flag)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for IDLE, then presents the operands for exactly one rising edge.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
        int guard_cnt = 0;
        @(negedge clk);
        while (busy && guard_cnt < 100) begin
            @(negedge clk);
            guard_cnt++;
        end
        if (busy) checkOutput("idle_wait", {63'd0, busy}, 64'd0);
        a  = av;
        b  = bv;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic waitDone(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int lat;
        applyStimulus(v.a, v.b);
        waitDone(lat);
        checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        checkOutput($sformatf("v%0d_R", idx), {32'd0, R}, {32'd0, v.r});
        checkOutput($sformatf("v%0d_flags", idx), {59'd0, flags}, {59'd0, v.f});
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_hold", idx), {31'd0, done, R}, {32'd0, v.r});
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29};
        vecs[2]  = '{32'hC0E00000, 32'h40000000, 32'hC0600000, 5'b00000, 29};
        vecs[3]  = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 5'b00001, 29};
        vecs[4]  = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'b00000, 29};
        vecs[5]  = '{32'h00800000, 32'h3F800000, 32'h00800000, 5'b00000, 29};
        vecs[6]  = '{32'h00800000, 32'h3F800001, 32'h00000000, 5'b00011, 29};
        vecs[7]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 5'b00101, 29};
        vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 29};
        vecs[9]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2};
        vecs[10] = '{32'h80000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2};
        vecs[12] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 2};
        vecs[13] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2};
        vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2};
        vecs[15] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 2};
        vecs[16] = '{32'h00000000, 32'hC0000000, 32'h80000000, 5'b00000, 2};
        vecs[17] = '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, 2};
        vecs[18] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 2};
        vecs[19] = '{32'h40000000, 32'h7FA00000, 32'h7FC00000, 5'b10000, 2};
        vecs[20] = '{32'hC0000000, 32'hFFC00001, 32'h7FC00000, 5'b00000, 2};
        vecs[21] = '{32'h80000000, 32'hC0400000, 32'h00000000, 5'b00000, 2};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {24'd0, busy, done, R, io_flag, dz_flag, of_flag, uf_flag, i_flag}, 64'd0);
        @(negedge clk);
        arst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            runVector(vecs[i], i);
        end

        // A second start while busy must neither disturb nor queue.
        applyStimulus(32'h40C00000, 32'h40000000);
        checkOutput("busy_cycle1", {63'd0, busy}, 64'd1);
        repeat (4) @(posedge clk);
        a  = 32'h3F800000;
        b  = 32'h40400000;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        checkOutput("busy_cycle28", {62'd0, busy, done}, 64'd2);
        @(posedge clk);
        #1;
        checkOutput("ignored_en_done", {63'd0, done}, 64'd1);
        checkOutput("ignored_en_R", {32'd0, R}, 64'h40400000);
        checkOutput("ignored_en_flags", {59'd0, flags}, 64'd0);
        seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checkOutput("no_queued_op", 64'(seen), 64'd0);

        // Asynchronous abort mid-division.
        applyStimulus(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #2;
        arst = 1'b0;
        #1;
        checkOutput("abort_clear", {24'd0, busy, done, R, io_flag, dz_flag, of_flag, uf_flag, i_flag}, 64'd0);
        @(negedge clk);
        arst = 1'b1;
        applyStimulus(32'h3F800000, 32'h40400000);
        waitDone(lat);
        checkOutput("post_abort_latency", 64'(lat), 64'd29);
        checkOutput("post_abort_R", {32'd0, R}, 64'h3EAAAAAB);
        checkOutput("post_abort_flags", {59'd0, flags}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
Iterative single-precision IEEE-754 divider: the division datapath behind the sel==1 path of the FP mult/div unit, producing R and the five exception flags.
- Accepts one operand pair per operation.
- Resolves special operands in a short bypass path.
- Otherwise runs a radix-2 restoring mantissa division, then normalises and rounds (round-to-nearest-even).
- Result and flags are held stable until the next operation completes.

Parameters:
EXP_W, 8, exponent width; only the default is verified.
MAN_W, 23, stored mantissa width; only the default is verified.
QBITS, MAN_W+4 (=27), quotient bits produced; one per DIVIDE cycle.

Ports:
clk  in  1  clock; all state updates on rising edge.
arst  in  1  asynchronous, active-low reset.
en  in  1  start request, sampled only in IDLE.
a  in  32  dividend, IEEE-754 binary32.
b  in  32  divisor, IEEE-754 binary32.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse when R/flags update.
R  out  32  quotient.
io_flag  out  1  invalid operation.
dz_flag  out  1  divide by zero.
of_flag  out  1  overflow.
uf_flag  out  1  underflow.
i_flag  out  1  inexact.

Behaviour:
- Reset (arst=0, asynchronous, any state): state=IDLE; busy, done, R and all flags = 0; counter and datapath registers cleared. In-flight operation discarded; no done is produced for it.
- States and transitions:
  - IDLE -> SPECIAL if en=1 and either operand is special.
  - IDLE -> DIVIDE if en=1 otherwise; a and b are captured on this edge.
  - DIVIDE runs QBITS cycles -> ROUND.
  - ROUND -> DONE.
  - SPECIAL -> DONE.
  - DONE -> IDLE. done=1 only in DONE.
- en while busy=1 is ignored; no queueing. Inputs a/b are don't-care after the capture edge.
- Latency (from the edge sampling en=1 to done high): QBITS+2 = 29 cycles for normal operands; 2 cycles for special operands.
- Back-to-back: en may be asserted in the cycle after done, which is IDLE.
- Input classification:
  - Exponent 0 is treated as zero; subnormal inputs are flushed (DAZ).
  - Exponent all-ones with mantissa 0 is inf; with mantissa !=0 is NaN.
  - A signaling NaN has mantissa bit 22 = 0.
- Sign of R = a[31]^b[31] for all non-NaN results.
- Special results (flags not listed are 0):
  - Any NaN input -> 0x7FC00000; io_flag=1 only if that NaN is signaling.
  - 0/0 or inf/inf -> 0x7FC00000, io_flag=1.
  - finite nonzero/0 -> signed inf, dz_flag=1.
  - 0/finite nonzero -> signed 0.
  - inf/finite -> signed inf.
  - finite/inf -> signed 0.
- Mantissa division:
  - ma={1,a[22:0]}, mb={1,b[22:0]}; 24 bits each.
  - Restoring division yields Q=floor(ma*2^26/mb), QBITS wide, with 2^25 <= Q < 2^27, plus a remainder.
  - If Q[26]=1: mant=Q[26:3], guard=Q[2], sticky=|Q[1:0] | (rem!=0), exponent adjust 0.
  - Else: mant=Q[25:2], guard=Q[1], sticky=Q[0] | (rem!=0), exponent adjust -1.
- Exponent: e = ea - eb + 127 + adjust, computed signed at 10 bits.
- Rounding: round up when guard & (sticky | mant[0]). A carry out of the mantissa increments e and shifts mant right by one.
- After rounding:
  - e >= 255 -> signed inf, of_flag=1, i_flag=1.
  - e <= 0 -> signed zero (FTZ), uf_flag=1, i_flag=1.
  - Otherwise R={sign, e[7:0], mant[22:0]}, i_flag = guard|sticky.
- R and flags change only on the DONE-entry edge and hold until the next DONE or reset. Flags are per-operation, not sticky across operations.

Decomposition:
- Shared package fp_pkg:
  - binary32 field widths and bias 127;
  - constants QNAN 0x7FC00000 and POS_INF 0x7F800000;
  - enum typedef div_state_t {IDLE, SPECIAL, DIVIDE, ROUND, DONE};
  - packed struct fp_class_t {is_zero, is_inf, is_nan, is_snan};
  - function classify(binary32) returning fp_class_t.
- Sub-module fp_mant_div_core: restoring iteration datapath (partial remainder, divisor, quotient shift register, bit counter). Ports: start, ma, mb, Q, rem, finished.
- fp_div_iter owns the FSM, special-case logic, exponent path, rounding and output registers.

Test Plan:
- a=0x40C00000, b=0x40000000, en pulse -> done after 29 cycles, R=0x40400000, all flags 0, busy high during cycles 1..28.
- a=0x3F800000, b=0x40400000 -> R=0x3EAAAAAB, i_flag=1, other flags 0.
- Special operands, each done after 2 cycles:
  - a=0x3F800000, b=0x00000000 -> R=0x7F800000, dz_flag=1.
  - a=0x80000000, b=0x00000000 -> R=0x7FC00000, io_flag=1.
  - a=0x7F800001 -> R=0x7FC00000, io_flag=1.
- a=0x7F000000, b=0x00800000 -> R=0x7F800000, of_flag=1, i_flag=1; then a=0x00800000, b=0x40000000 -> R=0x00000000, uf_flag=1, i_flag=1.
- Start 6.0/2.0, pulse en again at cycle 5 (ignored), then drop arst at cycle 10 -> busy/done/R/flags 0 immediately. Release arst; next en with 1.0/3.0 completes normally in 29 cycles.
